// File: rtl/regfile_sb_if.sv
// Decode/write-back bus of the regfile_sb register file: read ports, busy flags,
// issue handshake and write-back strobe.
interface regfile_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] read_rs;
    logic [DATA_W-1:0] read_rt;
    logic              rs_busy;
    logic              rt_busy;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_ready;
    logic              reg_write;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] write_data;

    modport master (
        output rs, rt, issue_valid, issue_rd, reg_write, rd, write_data,
        input  read_rs, read_rt, rs_busy, rt_busy, issue_ready
    );

    modport slave (
        input  rs, rt, issue_valid, issue_rd, reg_write, rd, write_data,
        output read_rs, read_rt, rs_busy, rt_busy, issue_ready
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file (r0 = 0) with a per-register pending-write scoreboard for RAW stalls.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int PEND_W = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int NREGS = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    // Views indexed by register number; entry 0 is the constant-zero register.
    logic [DATA_W-1:0] rview [NREGS];
    logic [PEND_W-1:0] pview [NREGS];
    logic              issue_acc;

    assign rview[0] = '0;
    assign pview[0] = '0;

    assign bus.issue_ready = (bus.issue_rd == '0) || (pview[bus.issue_rd] != PEND_MAX);
    assign issue_acc       = bus.issue_valid && bus.issue_ready;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
        logic [DATA_W-1:0] data;
        logic [PEND_W-1:0] cnt;
        logic              hit;
        logic              inc;

        assign hit = bus.reg_write && (bus.rd == IDX);
        assign inc = issue_acc && (bus.issue_rd == IDX);

        // An issue and a retire to the same register in one cycle cancel out.
        always_ff @(posedge clk) begin
            if (rst) begin
                data <= '0;
                cnt  <= '0;
            end else begin
                if (hit) data <= bus.write_data;
                if (inc && !hit)
                    cnt <= cnt + PEND_W'(1);
                else if (hit && !inc && cnt != '0)
                    cnt <= cnt - PEND_W'(1);
            end
        end

        assign rview[i] = data;
        assign pview[i] = cnt;
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_rs;
    logic fwd_rt;

    assign fwd_rs = bus.reg_write && (bus.rd != '0) && (bus.rd == bus.rs);
    assign fwd_rt = bus.reg_write && (bus.rd != '0) && (bus.rd == bus.rt);

    assign bus.read_rs = fwd_rs ? bus.write_data : rview[bus.rs];
    assign bus.read_rt = fwd_rt ? bus.write_data : rview[bus.rt];

    // A write retiring the last pending producer resolves the hazard this cycle.
    assign bus.rs_busy = (bus.rs != '0) && (pview[bus.rs] != '0) &&
                         !(fwd_rs && pview[bus.rs] == PEND_W'(1));
    assign bus.rt_busy = (bus.rt != '0) && (pview[bus.rt] != '0) &&
                         !(fwd_rt && pview[bus.rt] == PEND_W'(1));
`else
    assign bus.read_rs = rview[bus.rs];
    assign bus.read_rt = rview[bus.rt];
    assign bus.rs_busy = (bus.rs != '0) && (pview[bus.rs] != '0);
    assign bus.rt_busy = (bus.rt != '0) && (pview[bus.rt] != '0);
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations are hand-computed and
// follow REGFILE_BYPASS_EN when the bypass build is selected.
module tb_regfile_sb;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.reg_write   = 1'b0;
        bus.rd          = '0;
        bus.write_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.rs = 3'd0;
        bus.rt = 3'd3;
        step();
        step();
        rst = 1'b0;
        bus.issue_rd = 3'd5;
        #1;
        n_cmp++; if (bus.read_rs !== 16'h0000) begin n_bad++; $display("FAIL reset_read_rs: got %h want 0000", bus.read_rs); end
        n_cmp++; if (bus.read_rt !== 16'h0000) begin n_bad++; $display("FAIL reset_read_rt: got %h want 0000", bus.read_rt); end
        n_cmp++; if ({bus.rs_busy, bus.rt_busy} !== 2'b00) begin n_bad++; $display("FAIL reset_busy: got %b want 00", {bus.rs_busy, bus.rt_busy}); end
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_issue_ready: got %b want 1", bus.issue_ready); end
        // Write to r0 must be dropped.
        bus.reg_write  = 1'b1;
        bus.rd         = 3'd0;
        bus.write_data = 16'hBEEF;
        step();
        idle();
        bus.rs = 3'd0;
        #1;
        n_cmp++; if (bus.read_rs !== 16'h0000) begin n_bad++; $display("FAIL r0_write_dropped: got %h want 0000", bus.read_rs); end
        // Issues to r0 are always ready and never make r0 busy.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 3'd0;
        step();
        step();
        step();
        step();
        #1;
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL r0_issue_ready: got %b want 1", bus.issue_ready); end
        n_cmp++; if (bus.rs_busy !== 1'b0) begin n_bad++; $display("FAIL r0_busy: got %b want 0", bus.rs_busy); end
        idle();
    endtask

    task automatic test_write_read();
        bus.reg_write  = 1'b1;
        bus.rd         = 3'd5;
        bus.write_data = 16'h1234;
        step();
        idle();
        bus.rs = 3'd5;
        bus.rt = 3'd5;
        #1;
        n_cmp++; if (bus.read_rt !== 16'h1234) begin n_bad++; $display("FAIL wr_read_rt: got %h want 1234", bus.read_rt); end
        n_cmp++; if (bus.read_rs !== 16'h1234) begin n_bad++; $display("FAIL wr_read_rs: got %h want 1234", bus.read_rs); end
        n_cmp++; if (bus.rs_busy !== 1'b0) begin n_bad++; $display("FAIL wr_spurious_busy: got %b want 0", bus.rs_busy); end
    endtask

    task automatic test_scoreboard();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 3'd3;
        step();
        step();
        idle();
        bus.rs = 3'd3;
        bus.rt = 3'd3;
        #1;
        n_cmp++; if (bus.rs_busy !== 1'b1) begin n_bad++; $display("FAIL sb_busy_pend2: got %b want 1", bus.rs_busy); end
        bus.reg_write  = 1'b1;
        bus.rd         = 3'd3;
        bus.write_data = 16'h0033;
        step();
        idle();
        #1;
        n_cmp++; if (bus.rs_busy !== 1'b1) begin n_bad++; $display("FAIL sb_busy_pend1_rs: got %b want 1", bus.rs_busy); end
        n_cmp++; if (bus.rt_busy !== 1'b1) begin n_bad++; $display("FAIL sb_busy_pend1_rt: got %b want 1", bus.rt_busy); end
        bus.reg_write  = 1'b1;
        bus.rd         = 3'd3;
        bus.write_data = 16'h0333;
        step();
        idle();
        #1;
        n_cmp++; if (bus.rs_busy !== 1'b0) begin n_bad++; $display("FAIL sb_busy_pend0: got %b want 0", bus.rs_busy); end
        n_cmp++; if (bus.read_rs !== 16'h0333) begin n_bad++; $display("FAIL sb_read: got %h want 0333", bus.read_rs); end
    endtask

    task automatic test_saturation();
        bus.rs          = 3'd4;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 3'd4;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL sat_ready_issue%0d: got %b want 1", k, bus.issue_ready); end
            step();
        end
        #1;
        n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL sat_ready_full: got %b want 0", bus.issue_ready); end
        // Refused 4th issue: counter must stay saturated, not wrap.
        step();
        #1;
        n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL sat_no_wrap: got %b want 0", bus.issue_ready); end
        n_cmp++; if (bus.rs_busy !== 1'b1) begin n_bad++; $display("FAIL sat_busy: got %b want 1", bus.rs_busy); end
        // Retire once (3 -> 2), then issue+retire together must hold at 2.
        idle();
        bus.reg_write = 1'b1;
        bus.rd        = 3'd4;
        step();
        #1;
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL sat_ready_pend2: got %b want 1", bus.issue_ready); end
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 3'd4;
        step();
        idle();
        bus.issue_rd = 3'd4;
        #1;
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL sat_simul_hold_ready: got %b want 1", bus.issue_ready); end
        // One more issue reaches 3 again, proving the counter sat at 2.
        bus.issue_valid = 1'b1;
        step();
        idle();
        bus.issue_rd = 3'd4;
        #1;
        n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL sat_simul_back_to_3: got %b want 0", bus.issue_ready); end
        // Drain: busy stays set until the third retire.
        for (int k = 0; k < 3; k++) begin
            bus.reg_write = 1'b1;
            bus.rd        = 3'd4;
            step();
            bus.reg_write = 1'b0;
            #1;
            n_cmp++; if (bus.rs_busy !== (k < 2)) begin n_bad++; $display("FAIL sat_drain%0d: got %b want %b", k, bus.rs_busy, (k < 2)); end
        end
        idle();
    endtask

    task automatic test_bypass();
        bus.reg_write  = 1'b1;
        bus.rd         = 3'd2;
        bus.write_data = 16'h1111;
        step();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 3'd2;
        step();
        idle();
        bus.rs         = 3'd2;
        bus.rt         = 3'd2;
        bus.reg_write  = 1'b1;
        bus.rd         = 3'd2;
        bus.write_data = 16'hA5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        n_cmp++; if (bus.read_rs !== 16'hA5A5) begin n_bad++; $display("FAIL byp_read_rs: got %h want a5a5", bus.read_rs); end
        n_cmp++; if (bus.read_rt !== 16'hA5A5) begin n_bad++; $display("FAIL byp_read_rt: got %h want a5a5", bus.read_rt); end
        n_cmp++; if ({bus.rs_busy, bus.rt_busy} !== 2'b00) begin n_bad++; $display("FAIL byp_busy: got %b want 00", {bus.rs_busy, bus.rt_busy}); end
`else
        n_cmp++; if (bus.read_rs !== 16'h1111) begin n_bad++; $display("FAIL byp_read_rs: got %h want 1111", bus.read_rs); end
        n_cmp++; if (bus.read_rt !== 16'h1111) begin n_bad++; $display("FAIL byp_read_rt: got %h want 1111", bus.read_rt); end
        n_cmp++; if ({bus.rs_busy, bus.rt_busy} !== 2'b11) begin n_bad++; $display("FAIL byp_busy: got %b want 11", {bus.rs_busy, bus.rt_busy}); end
`endif
        step();
        idle();
        #1;
        n_cmp++; if (bus.read_rs !== 16'hA5A5) begin n_bad++; $display("FAIL byp_next_read: got %h want a5a5", bus.read_rs); end
        n_cmp++; if (bus.rs_busy !== 1'b0) begin n_bad++; $display("FAIL byp_next_busy: got %b want 0", bus.rs_busy); end
    endtask

    task automatic test_reset_mid();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 3'd6;
        step();
        step();
        idle();
        bus.rs = 3'd6;
        #1;
        n_cmp++; if (bus.rs_busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before: got %b want 1", bus.rs_busy); end
        // Issue and write in the reset cycle must be ignored.
        rst             = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 3'd6;
        bus.reg_write   = 1'b1;
        bus.rd          = 3'd6;
        bus.write_data  = 16'h7777;
        step();
        rst = 1'b0;
        idle();
        #1;
        n_cmp++; if (bus.rs_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_after: got %b want 0", bus.rs_busy); end
        n_cmp++; if (bus.read_rs !== 16'h0000) begin n_bad++; $display("FAIL rmid_read_after: got %h want 0000", bus.read_rs); end
        bus.reg_write  = 1'b1;
        bus.rd         = 3'd6;
        bus.write_data = 16'h0042;
        step();
        idle();
        bus.issue_rd = 3'd6;
        #1;
        n_cmp++; if (bus.read_rs !== 16'h0042) begin n_bad++; $display("FAIL rmid_spurious_read: got %h want 0042", bus.read_rs); end
        n_cmp++; if (bus.rs_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_spurious_busy: got %b want 0", bus.rs_busy); end
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", bus.issue_ready); end
        // One issue after the spurious retire must leave exactly one pending write.
        bus.issue_valid = 1'b1;
        step();
        idle();
        bus.reg_write = 1'b1;
        bus.rd        = 3'd6;
        step();
        idle();
        #1;
        n_cmp++; if (bus.rs_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_pend_not_underflow: got %b want 0", bus.rs_busy); end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        bus.rs = '0;
        bus.rt = '0;
        idle();
        test_reset();
        test_write_read();
        test_scoreboard();
        test_saturation();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
